// File: rtl/mips32_dmem_ctrl.sv
// Word-addressed data memory behind the MEM stage.
// Provides valid/ready request and response channels, programmable wait states, range errors and store squash.
//
// state  | meaning
// IDLE   | ready for a request; req_ready high
// WAIT   | counting down wait states on the latched request
// ACCESS | range check, then the array read or write
// RESP   | response register stage, then hold until rsp_ready
module mips32_dmem_ctrl #(
  parameter int DEPTH       = 1024,
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_kill,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  localparam logic [31:0] DEPTH_W   = 32'(DEPTH);
  localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt;
  logic        we_q, kill_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] rdata_q;
  logic        err_q, rsp_valid_q;
  logic [15:0] rd_count_q, wr_count_q;
  logic [31:0] mem [DEPTH];
  logic        accept, in_range, hs, do_write;

  // Full 32-bit compare so high address bits never alias into the array.
  assign in_range = (addr_q < DEPTH_W);
  assign accept   = (state == S_IDLE) && req_valid;
  assign hs       = rsp_valid_q && rsp_ready;
  assign do_write = (state == S_ACCESS) && in_range && we_q && !kill_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (req_valid) state_nxt = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
      S_WAIT:   if (wait_cnt == 4'd0) state_nxt = S_ACCESS;
      S_ACCESS: state_nxt = S_RESP;
      S_RESP:   if (hs) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == S_IDLE);
    rsp_valid = rsp_valid_q;
    rsp_rdata = rdata_q;
    rsp_err   = err_q;
    rd_count  = rd_count_q;
    wr_count  = wr_count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 4'd0;
      we_q     <= 1'b0;
      kill_q   <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
    end else if (accept) begin
      wait_cnt <= WAIT_INIT;
      we_q     <= req_we;
      kill_q   <= req_kill;
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
    end else if (state == S_WAIT && wait_cnt != 4'd0) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // The first RESP cycle loads rsp_valid, so the consumer always sees registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else if (state == S_ACCESS) begin
      err_q   <= !in_range;
      rdata_q <= (in_range && !we_q) ? mem[addr_q[ADDR_W-1:0]] : 32'd0;
    end else if (state == S_RESP) begin
      if (hs) begin
        rsp_valid_q <= 1'b0;
        rdata_q     <= 32'd0;
        err_q       <= 1'b0;
      end else begin
        rsp_valid_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count_q <= 16'd0;
      wr_count_q <= 16'd0;
    end else if (state == S_ACCESS && in_range) begin
      if (!we_q && rd_count_q != 16'hFFFF) rd_count_q <= rd_count_q + 16'd1;
      if (do_write && wr_count_q != 16'hFFFF) wr_count_q <= wr_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) mem[addr_q[ADDR_W-1:0]] <= wdata_q;
  end

endmodule

// File: tb/tb_mips32_dmem_ctrl.sv
// Directed bench for mips32_dmem_ctrl with WAIT_CYCLES=2.
// Expected values are hand-computed constants.
module tb_mips32_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_kill;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [15:0] rd_count, wr_count;

  int cmp_cnt = 0;
  int err_cnt = 0;

  mips32_dmem_ctrl #(.DEPTH(1024), .ADDR_W(10), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_kill(req_kill),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  // Issues one request; returns response fields and the edge count from acceptance to rsp_valid (-1 on timeout).
  // Completes the handshake only when rsp_ready is already high.
  task automatic do_req(input logic we, input logic kill, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic err, output int lat);
    @(negedge clk);
    req_we = we; req_kill = kill; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) begin lat = i; break; end
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    if (rsp_ready && lat > 0) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    cmp_cnt += 6;
    if (req_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    if (rsp_rdata !== 32'd0) begin err_cnt++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
    if (rsp_err !== 1'b0) begin err_cnt++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
    if (rd_count !== 16'd0) begin err_cnt++; $display("FAIL reset_rd_count: got %h want 0", rd_count); end
    if (wr_count !== 16'd0) begin err_cnt++; $display("FAIL reset_wr_count: got %h want 0", wr_count); end
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic e; int lat;
    do_req(1'b1, 1'b0, 32'd5, 32'hDEADBEEF, rd, e, lat);
    cmp_cnt += 4;
    if (lat !== 4) begin err_cnt++; $display("FAIL sw_latency: got %0d want 4", lat); end
    if (e !== 1'b0) begin err_cnt++; $display("FAIL sw_err: got %b want 0", e); end
    if (rd !== 32'd0) begin err_cnt++; $display("FAIL sw_rdata: got %h want 0", rd); end
    if (req_ready !== 1'b1) begin err_cnt++; $display("FAIL sw_ready_after_hs: got %b want 1", req_ready); end
    do_req(1'b0, 1'b0, 32'd5, 32'd0, rd, e, lat);
    cmp_cnt += 5;
    if (lat !== 4) begin err_cnt++; $display("FAIL lw_latency: got %0d want 4", lat); end
    if (rd !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL lw_rdata: got %h want deadbeef", rd); end
    if (e !== 1'b0) begin err_cnt++; $display("FAIL lw_err: got %b want 0", e); end
    if (wr_count !== 16'd1) begin err_cnt++; $display("FAIL sl_wr_count: got %0d want 1", wr_count); end
    if (rd_count !== 16'd1) begin err_cnt++; $display("FAIL sl_rd_count: got %0d want 1", rd_count); end
  endtask

  task automatic test_kill();
    logic [31:0] rd; logic e; int lat;
    do_req(1'b1, 1'b0, 32'd7, 32'h0, rd, e, lat);
    do_req(1'b1, 1'b1, 32'd7, 32'h12345678, rd, e, lat);
    cmp_cnt += 3;
    if (lat !== 4) begin err_cnt++; $display("FAIL kill_latency: got %0d want 4", lat); end
    if (e !== 1'b0) begin err_cnt++; $display("FAIL kill_err: got %b want 0", e); end
    if (wr_count !== 16'd2) begin err_cnt++; $display("FAIL kill_wr_count: got %0d want 2", wr_count); end
    do_req(1'b0, 1'b1, 32'd7, 32'd0, rd, e, lat);
    cmp_cnt += 2;
    if (rd !== 32'h0) begin err_cnt++; $display("FAIL kill_lw_rdata: got %h want 0", rd); end
    if (rd_count !== 16'd2) begin err_cnt++; $display("FAIL kill_rd_count: got %0d want 2", rd_count); end
  endtask

  task automatic test_range();
    logic [31:0] rd; logic e; int lat;
    do_req(1'b1, 1'b0, 32'd0, 32'hA5A50000, rd, e, lat);
    do_req(1'b0, 1'b0, 32'd1024, 32'd0, rd, e, lat);
    cmp_cnt += 2;
    if (e !== 1'b1) begin err_cnt++; $display("FAIL oor_lw_err: got %b want 1", e); end
    if (rd !== 32'd0) begin err_cnt++; $display("FAIL oor_lw_rdata: got %h want 0", rd); end
    do_req(1'b1, 1'b0, 32'h0000_0400, 32'hFFFFFFFF, rd, e, lat);
    cmp_cnt += 2;
    if (e !== 1'b1) begin err_cnt++; $display("FAIL oor_sw_err: got %b want 1", e); end
    if (rd !== 32'd0) begin err_cnt++; $display("FAIL oor_sw_rdata: got %h want 0", rd); end
    do_req(1'b1, 1'b0, 32'h8000_0005, 32'h0BADF00D, rd, e, lat);
    cmp_cnt += 1;
    if (e !== 1'b1) begin err_cnt++; $display("FAIL oor_high_err: got %b want 1", e); end
    cmp_cnt += 2;
    if (wr_count !== 16'd3) begin err_cnt++; $display("FAIL oor_wr_count: got %0d want 3", wr_count); end
    if (rd_count !== 16'd2) begin err_cnt++; $display("FAIL oor_rd_count: got %0d want 2", rd_count); end
    do_req(1'b0, 1'b0, 32'd0, 32'd0, rd, e, lat);
    cmp_cnt += 2;
    if (rd !== 32'hA5A50000) begin err_cnt++; $display("FAIL no_alias_mem0: got %h want a5a50000", rd); end
    do_req(1'b0, 1'b0, 32'd5, 32'd0, rd, e, lat);
    if (rd !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL no_alias_mem5: got %h want deadbeef", rd); end
  endtask

  task automatic test_hold();
    logic [31:0] rd; logic e; int lat;
    @(negedge clk);
    rsp_ready = 1'b0;
    do_req(1'b0, 1'b0, 32'd5, 32'd0, rd, e, lat);
    cmp_cnt += 1;
    if (lat !== 4) begin err_cnt++; $display("FAIL hold_latency: got %0d want 4", lat); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      cmp_cnt += 4;
      if (rsp_valid !== 1'b1) begin err_cnt++; $display("FAIL hold_valid[%0d]: got %b want 1", i, rsp_valid); end
      if (rsp_rdata !== 32'hDEADBEEF) begin err_cnt++; $display("FAIL hold_rdata[%0d]: got %h want deadbeef", i, rsp_rdata); end
      if (rsp_err !== 1'b0) begin err_cnt++; $display("FAIL hold_err[%0d]: got %b want 0", i, rsp_err); end
      if (req_ready !== 1'b0) begin err_cnt++; $display("FAIL hold_req_ready[%0d]: got %b want 0", i, req_ready); end
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    cmp_cnt += 3;
    if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL hold_hs_valid: got %b want 0", rsp_valid); end
    if (req_ready !== 1'b1) begin err_cnt++; $display("FAIL hold_hs_ready: got %b want 1", req_ready); end
    if (rd_count !== 16'd5) begin err_cnt++; $display("FAIL hold_rd_count: got %0d want 5", rd_count); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic e; int lat;
    do_req(1'b1, 1'b0, 32'd3, 32'h11112222, rd, e, lat);
    @(negedge clk);
    req_we = 1'b1; req_kill = 1'b0; req_addr = 32'd3; req_wdata = 32'h33334444; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    cmp_cnt += 4;
    if (rsp_valid !== 1'b0) begin err_cnt++; $display("FAIL rstmid_valid: got %b want 0", rsp_valid); end
    if (req_ready !== 1'b1) begin err_cnt++; $display("FAIL rstmid_ready: got %b want 1", req_ready); end
    if (rd_count !== 16'd0) begin err_cnt++; $display("FAIL rstmid_rd_count: got %0d want 0", rd_count); end
    if (wr_count !== 16'd0) begin err_cnt++; $display("FAIL rstmid_wr_count: got %0d want 0", wr_count); end
    do_req(1'b0, 1'b0, 32'd3, 32'd0, rd, e, lat);
    cmp_cnt += 2;
    if (rd !== 32'h11112222) begin err_cnt++; $display("FAIL rstmid_old_data: got %h want 11112222", rd); end
    if (rd_count !== 16'd1) begin err_cnt++; $display("FAIL rstmid_rd_after: got %0d want 1", rd_count); end
  endtask

  task automatic test_saturation();
    logic [31:0] rd; logic e; int lat;
    logic [15:0] exp_rd [3];
    exp_rd[0] = 16'hFFFE; exp_rd[1] = 16'hFFFF; exp_rd[2] = 16'hFFFF;
    // Preload the counters near saturation instead of spending 64k transactions.
    @(negedge clk);
    dut.rd_count_q <= 16'hFFFD;
    dut.wr_count_q <= 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      do_req(1'b0, 1'b0, 32'd3, 32'd0, rd, e, lat);
      cmp_cnt += 1;
      if (rd_count !== exp_rd[i]) begin err_cnt++; $display("FAIL rd_sat[%0d]: got %h want %h", i, rd_count, exp_rd[i]); end
    end
    for (int i = 0; i < 2; i++) begin
      do_req(1'b1, 1'b0, 32'd9, 32'h5A5A5A5A, rd, e, lat);
      cmp_cnt += 1;
      if (wr_count !== 16'hFFFF) begin err_cnt++; $display("FAIL wr_sat[%0d]: got %h want ffff", i, wr_count); end
    end
    do_req(1'b0, 1'b0, 32'd9, 32'd0, rd, e, lat);
    cmp_cnt += 1;
    if (rd !== 32'h5A5A5A5A) begin err_cnt++; $display("FAIL sat_store_data: got %h want 5a5a5a5a", rd); end
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_kill = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b1;
    #23;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    test_store_load();
    test_kill();
    test_range();
    test_hold();
    test_reset_mid();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/mips32_dmem_ctrl.md
Name: mips32_dmem_ctrl

Overview:
- Data-memory controller that sits directly downstream of the pipeline's MEM stage.
- Serves LW/SW word accesses through a valid/ready request channel and a valid/ready response channel.
- Owns the 32-bit data storage and adds configurable wait states, which lets the core be exercised against a slow memory.
- Rejects out-of-range addresses with an error flag and supports squashing of stores issued under a taken branch.

Parameters:
DEPTH, 1024, number of 32-bit words in the storage array.
ADDR_W, 10, index width; must satisfy 2**ADDR_W == DEPTH.
WAIT_CYCLES, 2, extra cycles between request acceptance and the array access (0..15).

Ports:
clk  input  1  single clock for the block; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
req_valid  input  1  request present.
req_ready  output  1  controller can accept a request.
req_we  input  1  1 = store (SW), 0 = load (LW).
req_kill  input  1  squash: the store is accepted but not written (taken-branch shadow).
req_addr  input  32  word address (the ALUOut of LW/SW).
req_wdata  input  32  store data.
rsp_valid  output  1  response present.
rsp_ready  input  1  consumer accepts the response.
rsp_rdata  output  32  load data; 0 for stores and errors.
rsp_err  output  1  address was out of range.
rd_count  output  16  completed in-range loads, saturating.
wr_count  output  16  performed (non-killed, in-range) stores, saturating.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE and the wait counter clears.
  - Outputs: req_ready=1 (once rst_n=1), rsp_valid=0, rsp_rdata=0, rsp_err=0, rd_count=0, wr_count=0.
  - Storage contents are not reset.
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at an edge: latch we, kill, addr and wdata, and drop req_ready.
  - Next state is WAIT with counter=WAIT_CYCLES-1, or ACCESS if WAIT_CYCLES==0.
- WAIT:
  - Counter decrements once per cycle.
  - When the counter is 0, go to ACCESS.
  - Request inputs are ignored in this state; only the latched copies are used.
- ACCESS, one cycle. Range check: the request is out of range when latched addr >= DEPTH, upper bits included (no wrap-around).
  - Out of range: rsp_err=1, rsp_rdata=0, no write, counters unchanged.
  - Load in range: rsp_rdata=mem[addr[ADDR_W-1:0]], rd_count+1.
  - Store in range, kill=0: mem written, wr_count+1, rsp_rdata=0.
  - Store in range, kill=1: no write, wr_count unchanged, rsp_err=0, response still produced.
  - req_kill on a load has no effect.
  - Next state is RESP.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until a handshake edge with rsp_ready=1.
  - After the handshake: rsp_valid=0, return to IDLE, req_ready=1 in the next cycle.
  - No request overlap; one request is outstanding at a time.
- Latency: request accepted at edge N → rsp_valid high after edge N+WAIT_CYCLES+2 (assuming rsp_ready=1). The next request can be accepted at edge N+WAIT_CYCLES+4.
- Counters saturate at 16'hFFFF and never wrap.
- Reset mid-operation:
  - Any latched request is discarded.
  - A store not yet past its ACCESS edge is not written.
  - A pending response is dropped.
- Read-after-write: a load following a store to the same address returns the new data, since the write completes before the next request is accepted.
- Same-edge events: a req_valid arriving on the same edge as the RESP→IDLE transition is not accepted, because req_ready is low during RESP.

Test Plan:
- WAIT_CYCLES=2: store addr=5, data=32'hDEADBEEF, then load addr=5 → store response err=0; load rsp_rdata=32'hDEADBEEF; rsp_valid rises 4 edges after each acceptance; wr_count=1, rd_count=1.
- Store addr=7, data=32'h12345678, kill=1; then load addr=7 → the load returns the prior contents (preloaded 32'h0); wr_count unchanged; the store response is still given with err=0.
- Load addr=1024, then store addr=32'h0000_0400 → both responses have rsp_err=1 and rsp_rdata=0; mem[0] is unchanged (no alias); counters unchanged.
- Hold rsp_ready=0 for 5 cycles during RESP → rsp_valid, rsp_rdata and rsp_err stay stable and req_ready stays 0; the handshake completes on the cycle rsp_ready=1.
- Assert rst_n=0 while a store to addr=3 is in WAIT, then release and load addr=3 → old data is returned; after reset, outputs are rsp_valid=0 and req_ready=1, and counters are 0.
- Force rd_count to 16'hFFFF via 65535 loads (or a WAIT_CYCLES=0 fast run), then issue one more load → rd_count remains 16'hFFFF.
